// File: rtl/led_seq_pkg.sv
// Shared encodings and constants for the LED sequencer.
// The optional PWM dimming build (macro LED_SEQ_DIM_EN) sizes its counter with PWM_W.
package led_seq_pkg;

    localparam int unsigned RATE_W  = 2;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned PWM_W   = 4;
    localparam int unsigned MAX_LED = 64;

    typedef enum logic [MODE_W-1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Initial patterns at full bank width; truncated to N_LED by the user.
    localparam logic [MAX_LED-1:0] INIT_ALL_ONES = '1;
    localparam logic [MAX_LED-1:0] INIT_LSB      = MAX_LED'(1);
    localparam logic [MAX_LED-1:0] INIT_ZERO     = '0;

endpackage

// File: rtl/led_seq_controller_tick_prescaler.sv
// Clock-enable prescaler: o_tick is a one-cycle pulse every DIV_BASE*2^i_rate
// cycles, counted from the last cycle i_clr was high.
module tick_prescaler
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_BASE = 6250000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_tick
);

    localparam int unsigned PRE_W  = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam int unsigned RCNT_W = 3;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV_BASE - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [RCNT_W-1:0] r_rcnt;
    logic              w_base;
    logic [RCNT_W-1:0] w_rate_tc;

    assign w_rate_tc = RCNT_W'((4'd1 << i_rate) - 4'd1);
    assign w_base    = (r_pre == PRE_TC);
    assign o_tick    = w_base && (r_rcnt == w_rate_tc);

    // Base-tick counter followed by a modulo-2^rate base-tick counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre  <= '0;
            r_rcnt <= '0;
        end else if (i_clr) begin
            r_pre  <= '0;
            r_rcnt <= '0;
        end else begin
            r_pre <= w_base ? '0 : r_pre + PRE_W'(1);
            if (w_base) begin
                r_rcnt <= (r_rcnt == w_rate_tc) ? '0 : r_rcnt + RCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_controller.sv
// LED bank sequencer: start/stop handshake, prescaled step pulses, four patterns.
// Define LED_SEQ_DIM_EN to add the i_duty PWM dimming input.
module led_seq_controller
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_BASE = 6250000,
    parameter int unsigned N_LED    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [RATE_W-1:0] i_rate,
`ifdef LED_SEQ_DIM_EN
    input  logic [PWM_W-1:0]  i_duty,
`endif
    output logic              o_busy,
    output logic              o_step,
    output logic [N_LED-1:0]  o_led
);

    state_e             r_state;
    mode_e              r_mode;
    logic [RATE_W-1:0]  r_rate;
    logic               r_dir;
    logic [N_LED-1:0]   r_pat;
    logic               r_busy;
    logic               r_step;

    logic               w_tick;
    logic               w_clr;
    logic [N_LED-1:0]   w_init_pat;
    logic [N_LED-1:0]   w_next_pat;
    logic               w_next_dir;

    // Prescaler is held cleared while idle so the first step lands a full period after start.
    assign w_clr = (r_state == ST_IDLE);

    tick_prescaler #(
        .DIV_BASE (DIV_BASE)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_rate (r_rate),
        .o_tick (w_tick)
    );

    always_comb begin
        w_init_pat = N_LED'(INIT_ZERO);
        case (mode_e'(i_mode))
            MODE_BLINK:  w_init_pat = N_LED'(INIT_ALL_ONES);
            MODE_CHASE:  w_init_pat = N_LED'(INIT_LSB);
            MODE_BOUNCE: w_init_pat = N_LED'(INIT_LSB);
            MODE_COUNT:  w_init_pat = N_LED'(INIT_ZERO);
            default:     w_init_pat = N_LED'(INIT_ZERO);
        endcase
    end

    // Bounce flips direction on the step that lands on an end bit.
    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        case (r_mode)
            MODE_BLINK: w_next_pat = ~r_pat;
            MODE_CHASE: w_next_pat = {r_pat[N_LED-2:0], r_pat[N_LED-1]};
            MODE_BOUNCE: begin
                if (r_dir) begin
                    w_next_pat = r_pat << 1;
                    if (w_next_pat[N_LED-1]) w_next_dir = 1'b0;
                end else begin
                    w_next_pat = r_pat >> 1;
                    if (w_next_pat[0]) w_next_dir = 1'b1;
                end
            end
            MODE_COUNT: w_next_pat = r_pat + N_LED'(1);
            default:    w_next_pat = r_pat;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_BLINK;
            r_rate  <= '0;
            r_dir   <= 1'b0;
            r_pat   <= '0;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode_e'(i_mode);
                        r_rate  <= i_rate;
                        r_pat   <= w_init_pat;
                        r_dir   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_step <= 1'b1;
                        r_pat  <= w_next_pat;
                        r_dir  <= w_next_dir;
                    end
                    if (i_stop) r_state <= ST_STOPPING;
                end
                ST_STOPPING: begin
                    if (w_tick) begin
                        r_step  <= 1'b1;
                        r_pat   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_step = r_step;

`ifdef LED_SEQ_DIM_EN
    logic [PWM_W-1:0] r_pwm;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pwm <= '0;
        else       r_pwm <= r_pwm + PWM_W'(1);
    end

    assign o_led = r_pat & {N_LED{r_pwm < i_duty}};
`else
    assign o_led = r_pat;
`endif

endmodule
